// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
// Optional 2-entry skid buffering per channel: STREAM_DEMUX_SKID_EN.
package stream_demux_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] ch_idx_t;

endpackage

// File: rtl/demux_out_slice.sv
// One downstream channel buffer: 1-entry register, or 2-entry skid
// buffer when STREAM_DEMUX_SKID_EN is defined.
module demux_out_slice #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

`ifdef STREAM_DEMUX_SKID_EN
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] e0_q, e0_d;
    logic [WIDTH-1:0] e1_q, e1_d;
    logic             push, pop;

    // Readiness comes from occupancy only, so no path from out_ready_i.
    assign in_ready_o  = (cnt_q != 2'd2);
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = e0_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
        cnt_d = cnt_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        unique case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) e0_d = in_data_i;
                else               e1_d = in_data_i;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                e0_d  = e1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    e0_d = in_data_i;
                end else begin
                    e0_d = e1_q;
                    e1_d = in_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end
`else
    logic             full_q, full_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign in_ready_o  = !full_q || out_ready_i;
    assign out_valid_o = full_q;
    assign out_data_o  = data_q;

    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (in_valid_i && in_ready_o) begin
            full_d = 1'b1;
            data_d = in_data_i;
        end else if (out_ready_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end
`endif

endmodule

// File: rtl/stream_demux_1_4.sv
// 1-to-4 valid/ready stream demultiplexer with per-channel buffers.
// Optional skid buffering per channel: define STREAM_DEMUX_SKID_EN.
module stream_demux_1_4
    import stream_demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [1:0]       up_sel,
    input  logic [WIDTH-1:0] up_data,
    output logic [3:0]       down_valid,
    input  logic [3:0]       down_ready,
    output logic [WIDTH-1:0] down_data0,
    output logic [WIDTH-1:0] down_data1,
    output logic [WIDTH-1:0] down_data2,
    output logic [WIDTH-1:0] down_data3
);

    logic [N_CH-1:0]  in_valid;
    logic [N_CH-1:0]  in_ready;
    logic [WIDTH-1:0] data [N_CH];
    ch_idx_t          sel;

    assign sel = ch_idx_t'(up_sel);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign in_valid[g] = up_valid && !rst && (sel == ch_idx_t'(g));

        demux_out_slice #(
            .WIDTH(WIDTH)
        ) u_slice (
            .clk        (clk),
            .rst        (rst),
            .in_valid_i (in_valid[g]),
            .in_ready_o (in_ready[g]),
            .in_data_i  (up_data),
            .out_valid_o(down_valid[g]),
            .out_ready_i(down_ready[g]),
            .out_data_o (data[g])
        );
    end

    // Held low through reset so nothing is accepted during that cycle.
    assign up_ready   = !rst && in_ready[sel];

    assign down_data0 = data[0];
    assign down_data1 = data[1];
    assign down_data2 = data[2];
    assign down_data3 = data[3];

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Directed self-checking bench for stream_demux_1_4.
// Works in both default and STREAM_DEMUX_SKID_EN builds.
module tb_stream_demux_1_4;

`ifdef STREAM_DEMUX_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       up_valid;
    logic       up_ready;
    logic [1:0] up_sel;
    logic [3:0] up_data;
    logic [3:0] down_valid;
    logic [3:0] down_ready;
    logic [3:0] down_data0;
    logic [3:0] down_data1;
    logic [3:0] down_data2;
    logic [3:0] down_data3;
    logic [3:0] xv;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stream_demux_1_4 #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .up_valid  (up_valid),
        .up_ready  (up_ready),
        .up_sel    (up_sel),
        .up_data   (up_data),
        .down_valid(down_valid),
        .down_ready(down_ready),
        .down_data0(down_data0),
        .down_data1(down_data1),
        .down_data2(down_data2),
        .down_data3(down_data3)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s,
                         input logic [3:0] d);
        up_valid = v;
        up_sel   = s;
        up_data  = d;
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        down_ready = 4'h0;
        drive(1'b1, 2'd0, 4'h0);
        step();
        step();

        // reset state; up_ready must be low while rst is high
        chk("rst_valid", 32'(down_valid), 32'h0);
        chk("rst_ready", 32'(up_ready), 32'h0);
        chk("rst_d0", 32'(down_data0), 32'h0);
        chk("rst_d3", 32'(down_data3), 32'h0);

        // routing, back-to-back, all consumers ready
        rst        = 1'b0;
        down_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'(i), 4'(4'hA + i));
            chk("route_rdy", 32'(up_ready), 32'h1);
            step();
            chk("route_valid", 32'(down_valid), 32'(4'b0001 << i));
        end
        chk("route_d3", 32'(down_data3), 32'hD);
        drive(1'b0, 2'd0, 4'h0);
        step();
        chk("route_idle", 32'(down_valid), 32'h0);
        chk("route_d0", 32'(down_data0), 32'hA);
        chk("route_d1", 32'(down_data1), 32'hB);
        chk("route_d2", 32'(down_data2), 32'hC);

        // X pass-through on channel 3
        xv = 4'bxxxx;
        drive(1'b1, 2'd3, xv);
        step();
        drive(1'b0, 2'd0, 4'h0);
        chk("x_valid", 32'(down_valid), 32'h8);
        chk("x_data", 32'(down_data3), 32'(xv));
        step();
        chk("x_drain", 32'(down_valid), 32'h0);

        // isolation: channel 0 stalled
        down_ready = 4'b1110;
        drive(1'b1, 2'd0, 4'h7);
        chk("iso_rdy0", 32'(up_ready), 32'h1);
        step();
`ifdef STREAM_DEMUX_SKID_EN
        drive(1'b1, 2'd0, 4'h8);
        chk("iso_rdy0b", 32'(up_ready), 32'h1);
        step();
`endif
        drive(1'b1, 2'd0, 4'h9);
        chk("iso_block0", 32'(up_ready), 32'h0);
        step();
        drive(1'b1, 2'd1, 4'hA);
        chk("iso_rdy1", 32'(up_ready), 32'h1);
        step();
        drive(1'b0, 2'd0, 4'h0);
        chk("iso_valid", 32'(down_valid), 32'h3);
        chk("iso_d1", 32'(down_data1), 32'hA);
        chk("iso_d0", 32'(down_data0), 32'h7);
        step();
        step();
        chk("iso_hold_v", 32'(down_valid), 32'h1);
        chk("iso_hold_d", 32'(down_data0), 32'h7);
        down_ready = 4'hF;
        step();
        chk("iso_rel_v", 32'(down_valid), 32'((DEPTH == 2) ? 1 : 0));
        step();
        chk("iso_empty", 32'(down_valid), 32'h0);

        // full-throughput stream to channel 2
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'd2, 4'(3 + i));
            chk("thr_rdy", 32'(up_ready), 32'h1);
            step();
            chk("thr_valid", 32'(down_valid), 32'h4);
            chk("thr_data", 32'(down_data2), 32'(3 + i));
        end
        drive(1'b0, 2'd0, 4'h0);
        step();
        chk("thr_idle", 32'(down_valid), 32'h0);

        // reset mid-operation discards buffered words
        down_ready = 4'h0;
        drive(1'b1, 2'd0, 4'h1);
        step();
        drive(1'b1, 2'd1, 4'h2);
        step();
        chk("mid_fill", 32'(down_valid), 32'h3);
        rst = 1'b1;
        drive(1'b1, 2'd2, 4'h3);
        chk("mid_rdy", 32'(up_ready), 32'h0);
        step();
        chk("mid_valid", 32'(down_valid), 32'h0);
        chk("mid_d0", 32'(down_data0), 32'h0);
        chk("mid_d1", 32'(down_data1), 32'h0);
        chk("mid_d2", 32'(down_data2), 32'h0);
        rst = 1'b0;
        drive(1'b0, 2'd0, 4'h0);
        down_ready = 4'hF;
        step();
        chk("mid_stale1", 32'(down_valid), 32'h0);
        step();
        chk("mid_stale2", 32'(down_valid), 32'h0);

        // simultaneous drain and accept on channel 3
        down_ready = 4'h0;
        drive(1'b1, 2'd3, 4'h9);
        step();
        chk("sim_full", 32'(down_valid), 32'h8);
        chk("sim_old", 32'(down_data3), 32'h9);
        down_ready = 4'h8;
        drive(1'b1, 2'd3, 4'h5);
        chk("sim_rdy", 32'(up_ready), 32'h1);
        step();
        chk("sim_valid", 32'(down_valid), 32'h8);
        chk("sim_new", 32'(down_data3), 32'h5);
        drive(1'b0, 2'd0, 4'h0);
        step();
        chk("sim_drain", 32'(down_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_demux_1_4.md
STREAM_DEMUX_1_4 -- requirements
Module: stream_demux_1_4

Interface
REQ-001 Parameter WIDTH, default 4, data width of every channel.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 up_valid  input  1  upstream word present.
REQ-005 up_ready  output  1  demux accepts upstream word this cycle.
REQ-006 up_sel  input  2  destination channel index, 0..3, qualified by up_valid.
REQ-007 up_data  input  WIDTH  upstream payload.
REQ-008 down_valid  output  4  per-channel word present, bit i = channel i.
REQ-009 down_ready  input  4  per-channel consumer accepts, bit i = channel i.
REQ-010 down_data0..down_data3  output  WIDTH each  per-channel payload.

Function
REQ-011 Upstream transfer occurs in a cycle where up_valid && up_ready; downstream transfer on channel i where down_valid[i] && down_ready[i].
REQ-012 An accepted word appears only on channel up_sel, bit-exact (X/Z bits propagate unchanged), with down_valid[up_sel] asserted the cycle after acceptance (latency 1).
REQ-013 Each channel holds its own buffer; words on one channel are delivered in acceptance order; channels are mutually independent.
REQ-014 A stalled channel (down_ready[i]=0, buffer full) blocks only words addressed to it; words for other channels are accepted.
REQ-015 up_ready depends on up_sel: asserted when the buffer of channel up_sel can take a word in this cycle (see REQ-021/022).
REQ-016 down_valid[i] and down_data i stay stable while down_valid[i] && !down_ready[i].
REQ-017 Simultaneous accept into and drain from the same channel in one cycle: both occur, occupancy unchanged, no bubble.
REQ-018 up_data, up_sel ignored when up_valid=0; no channel state changes.
REQ-019 Sustained throughput: one word per cycle to any channel whose consumer holds down_ready high.

Reset
REQ-020 While rst=1 at a rising edge: all buffers emptied, down_valid=4'b0000, down_data0..3=0, up_ready=0 during that cycle; reset mid-transfer discards buffered words without delivering them; first acceptance possible the cycle after rst deasserts.

Configuration
REQ-021 Without STREAM_DEMUX_SKID_EN: each channel is a 1-entry register; up_ready = !full[up_sel] || down_ready[up_sel] (combinational path from down_ready).
REQ-022 With STREAM_DEMUX_SKID_EN defined: each channel is a 2-entry skid buffer; up_ready = (occupancy[up_sel] < 2), no combinational path from down_ready to up_ready; latency still 1; ordering and REQ-013..019 unchanged.

Structure
REQ-023 Package stream_demux_pkg holds N_CH=4, SEL_W=2 and the channel index typedef.
REQ-024 Sub-module demux_out_slice implements one channel buffer (both configurations); top instantiates four, decodes up_sel into per-slice in_valid, muxes per-slice in_ready back to up_ready.

Verification
REQ-025 Routing: down_ready=4'hF, send ('ha,sel 0),('hb,1),('hc,2),('hd,3) back-to-back -> down_data0..3 = a,b,c,d, each down_valid one cycle after its acceptance, up_ready constantly 1.
REQ-026 X pass-through: send up_data=4'bxxxx sel 3 -> down_data3 === 4'bxxxx with down_valid[3]=1; channels 0..2 unaffected.
REQ-027 Isolation: down_ready=4'b1110, send 7 to sel 0 then 10 to sel 1 -> channel 0 holds 7 stable, up_ready drops for sel 0 (after 1 word, or 2 with SKID_EN), word 10 accepted and delivered on channel 1.
REQ-028 Order/full-throughput: down_ready[2]=1, stream 3,4,5,6 to sel 2 on consecutive cycles -> channel 2 emits 3,4,5,6 on consecutive cycles, no bubbles.
REQ-029 Reset mid-operation: fill channels 0 and 1 with down_ready=0, assert rst one cycle -> down_valid=0, down_data0..3=0, stale words never emerge after release.
REQ-030 Simultaneous events: channel 3 full, in one cycle down_ready[3]=1 and up_valid with sel 3 data 'h5 -> old word drained, 'h5 presented next cycle, occupancy unchanged.
